// File: rtl/mac_sched.sv
// rtl/mac_sched.sv - shared-MAC job scheduler for N_CH second-order filter channels
//
// Each channel raises a one-cycle rx strobe when a new sample arrives. The
// scheduler grants one channel at a time and walks the MAC through an
// 11-cycle job (two accumulate phases of N_TAPS steps each, an intermediate
// write, a result load and a state shift). Requests arriving while a channel
// is already pending overwrite the older sample and raise a sticky overrun.
//
// Build option: define MAC_SCHED_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (lowest channel index wins).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   rx        in   [N_CH] per-channel new-sample strobe
//   clr_ovr   in   clears all overrun flags (wins over a simultaneous set)
//   ch_sel    out  [2] channel granted the MAC (holds last grant when idle)
//   sel       out  [4] operand / coefficient step index
//   rst_acum  out  accumulator clear
//   leer      out  write rounded intermediate into channel state memory
//   desp      out  shift channel state memory
//   leer_y    out  load rounded result into channel output register
//   busy      out  high while a job is in progress
//   ovr       out  [N_CH] sticky per-channel overrun flags
module mac_sched #(
  parameter int N_CH   = 3,
  parameter int N_TAPS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] rx,
  input  logic            clr_ovr,
  output logic [1:0]      ch_sel,
  output logic [3:0]      sel,
  output logic            rst_acum,
  output logic            leer,
  output logic            desp,
  output logic            leer_y,
  output logic            busy,
  output logic [N_CH-1:0] ovr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_A,
    S_MA0,
    S_MA1,
    S_MA2,
    S_WR_F,
    S_CLR_B,
    S_MB3,
    S_MB4,
    S_MB5,
    S_WR_Y,
    S_SHIFT
  } state_t;

  // Second phase continues the coefficient index where the first left off.
  localparam logic [3:0] MB_BASE = 4'(N_TAPS);

  state_t          state;
  state_t          state_next;
  logic [N_CH-1:0] pending;
  logic            grant_hit;
  logic [1:0]      grant_ch;
  logic            take;
  logic [N_CH-1:0] grant_vec;

`ifndef MAC_SCHED_FIXED_PRIO_EN
  localparam logic [1:0] CH_LAST = 2'(N_CH - 1);
  logic [1:0] rr_ptr;  // first channel to examine on the next grant
`endif

  // Arbitration over pending requests.
  always_comb begin
    grant_hit = 1'b0;
    grant_ch  = 2'd0;
`ifdef MAC_SCHED_FIXED_PRIO_EN
    // Scan high to low so the lowest pending index is the last one kept.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_hit = 1'b1;
        grant_ch  = 2'(i);
      end
    end
`else
    // Scan rotation offsets from farthest to nearest so the channel closest
    // after the previous grant is the last one kept.
    for (int k = N_CH - 1; k >= 0; k--) begin
      for (int i = 0; i < N_CH; i++) begin
        if (pending[i] && (i == (int'(rr_ptr) + k) % N_CH)) begin
          grant_hit = 1'b1;
          grant_ch  = 2'(i);
        end
      end
    end
`endif
  end

  // A new grant is taken only from IDLE or at the tail of a job (SHIFT),
  // which lets back-to-back jobs run without an idle gap.
  assign take = grant_hit && ((state == S_IDLE) || (state == S_SHIFT));

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant_vec[i] = take && (grant_ch == 2'(i));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = S_IDLE;
    unique case (state)
      S_IDLE:  state_next = grant_hit ? S_CLR_A : S_IDLE;
      S_CLR_A: state_next = S_MA0;
      S_MA0:   state_next = S_MA1;
      S_MA1:   state_next = S_MA2;
      S_MA2:   state_next = S_WR_F;
      S_WR_F:  state_next = S_CLR_B;
      S_CLR_B: state_next = S_MB3;
      S_MB3:   state_next = S_MB4;
      S_MB4:   state_next = S_MB5;
      S_MB5:   state_next = S_WR_Y;
      S_WR_Y:  state_next = S_SHIFT;
      S_SHIFT: state_next = grant_hit ? S_CLR_A : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    sel      = 4'd0;
    rst_acum = 1'b0;
    leer     = 1'b0;
    desp     = 1'b0;
    leer_y   = 1'b0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_CLR_A: rst_acum = 1'b1;
      S_MA0:   sel = 4'd0;
      S_MA1:   sel = 4'd1;
      S_MA2:   sel = 4'd2;
      S_WR_F:  leer = 1'b1;
      S_CLR_B: rst_acum = 1'b1;
      S_MB3:   sel = MB_BASE;
      S_MB4:   sel = MB_BASE + 4'd1;
      S_MB5:   sel = MB_BASE + 4'd2;
      S_WR_Y:  leer_y = 1'b1;
      S_SHIFT: desp = 1'b1;
      default: ;
    endcase
  end

  // Request bookkeeping, overrun flags and grant registers. A strobe on the
  // same edge that grants its channel is a fresh request, not an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovr     <= '0;
      ch_sel  <= 2'd0;
    end else begin
      pending <= rx | (pending & ~grant_vec);
      if (clr_ovr) begin
        ovr <= '0;
      end else begin
        ovr <= ovr | (rx & pending & ~grant_vec);
      end
      if (take) begin
        ch_sel <= grant_ch;
      end
    end
  end

`ifndef MAC_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (take) begin
      rr_ptr <= (grant_ch == CH_LAST) ? 2'd0 : grant_ch + 2'd1;
    end
  end
`endif

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of filter channels sharing one MAC datapath (legal 1..4).
REQ-002 SHALL have parameter N_TAPS, default 3, operand steps per MAC phase (fixed; other values illegal).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port rx  input  N_CH  per-channel new-sample strobe, one cycle high.
REQ-006 SHALL have port clr_ovr  input  1  clears all overrun flags.
REQ-007 SHALL have port ch_sel  output  2  channel currently granted the MAC.
REQ-008 SHALL have port sel  output  4  operand/coefficient step index to the operand mux and coefficient ROM.
REQ-009 SHALL have port rst_acum  output  1  accumulator clear.
REQ-010 SHALL have port leer  output  1  write rounded intermediate f into the granted channel's state memory.
REQ-011 SHALL have port desp  output  1  shift state memory (f2<=f1, f1<=f).
REQ-012 SHALL have port leer_y  output  1  load rounded result into the granted channel's output register.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port ovr  output  N_CH  sticky per-channel overrun flags.

Function
REQ-015 SHALL latch rx[i] into pending[i] on the edge where rx[i]=1.
REQ-016 SHALL, in IDLE with any pending bit set, grant one channel, clear its pending bit and enter CLR_A on the next edge.
REQ-017 SHALL pick the grant round-robin, starting the search at the channel after the last one granted; after reset, channel 0 is searched first.
REQ-018 SHALL sequence states exactly: IDLE, CLR_A, MA0, MA1, MA2, WR_F, CLR_B, MB3, MB4, MB5, WR_Y, SHIFT, IDLE.
  - Each non-IDLE state lasts 1 cycle, giving 11 cycles per job.
REQ-019 SHALL drive the outputs per state (all others 0):
  - CLR_A, CLR_B: rst_acum=1.
  - MAk, MBk: sel=k.
  - WR_F: leer=1.
  - WR_Y: leer_y=1.
  - SHIFT: desp=1.
REQ-020 SHALL hold ch_sel constant from CLR_A through SHIFT, and hold the last granted value in IDLE.
REQ-021 SHALL, for rx[i] sampled at edge k with the MAC idle, assert leer_y in the cycle following edge k+10.
REQ-022 SHALL, when rx[i]=1 while pending[i]=1 and channel i is not being granted that edge, set ovr[i]; pending[i] stays 1.
  - The older sample is overwritten.
REQ-023 SHALL, when rx[i] arrives on the same edge that grants channel i, leave pending[i]=1 and not set ovr[i].
REQ-024 SHALL accept rx for the currently granted channel during its job as a new pending request, with no overrun.
REQ-025 SHALL go from SHIFT directly to CLR_A when another request is pending, with no IDLE cycle between jobs.
REQ-026 SHALL give clr_ovr precedence over a simultaneous overrun set, so ovr ends at 0.
REQ-027 SHALL ignore rx bits at index >= N_CH.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force IDLE and clear pending and ovr.
  - All outputs go to 0: ch_sel=0, sel=0, rst_acum=0, leer=0, desp=0, leer_y=0, busy=0.
  - The round-robin pointer returns to channel 0.
REQ-029 SHALL abandon any job interrupted by reset mid-sequence, issuing no further leer, leer_y or desp for it.
REQ-030 SHALL ignore rx on any edge where rst=1.

Configuration
REQ-031 SHALL, with MAC_SCHED_FIXED_PRIO_EN defined, replace round-robin with fixed priority (lowest index wins).
REQ-032 SHALL, without MAC_SCHED_FIXED_PRIO_EN, use the round-robin of REQ-017; all other behaviour is identical in both builds.

Verification
REQ-033 SHALL cover: rx=3'b001 at edge 5 -> ch_sel=0, state sequence as REQ-018, leer_y=1 in the cycle after edge 15, busy low from edge 17.
REQ-034 SHALL cover: rx=3'b111 in one cycle -> jobs run for channels 0, 1, 2 back-to-back, 33 busy cycles, leer_y three times spaced 11 cycles apart.
REQ-035 SHALL cover: rx[1] pulsed twice during channel-0 job -> ovr=3'b010, channel 1 served once; clr_ovr=1 -> ovr=0.
REQ-036 SHALL cover: rst=1 during MB4 -> next cycle busy=0, all outputs 0, no leer_y; a new rx[2] afterwards is served normally.
REQ-037 SHALL cover round-robin: channel 2 just served, then rx=3'b101 -> channel 0 is granted before channel 2.
  - Under MAC_SCHED_FIXED_PRIO_EN, the same stimulus with rx=3'b110 -> channel 1 is granted first.
REQ-038 SHALL cover: rx[0] on the same edge that grants channel 0 -> ovr[0]=0 and a second job for channel 0 follows immediately.
